// File: rtl/ysyx_22050550_pc_predict.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit direction counters.
// It trains on branch resolutions from ID and raises a flush on mispredicts and traps.
module ysyx_22050550_pc_predict #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = 'h80000000,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_npc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_is_cond,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic [XLEN-1:0] res_pred_npc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [1:0]             btb_cnt [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx   = pc[IDX_W+1:2];
  assign look_tag   = pc[XLEN-1:IDX_W+2];
  assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_taken = look_hit && btb_cnt[look_idx][1];
  assign pred_npc   = pred_taken ? btb_tgt[look_idx] : pc + XLEN'(4);

  logic [XLEN-1:0]  act_npc;
  logic             mispredict;

  assign act_npc    = res_taken ? res_target : res_pc + XLEN'(4);
  assign mispredict = res_valid && (res_pred_npc != act_npc);
  assign flush      = trap_valid || mispredict;

  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic             upd_taken;
  logic             wr_entry;
  logic             wr_cnt;
  logic [1:0]       cnt_next;

  assign res_idx   = res_pc[IDX_W+1:2];
  assign res_tag   = res_pc[XLEN-1:IDX_W+2];
  assign res_hit   = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
  // Jumps always train as taken and pin their counter at strongly taken.
  assign upd_taken = res_taken || !res_is_cond;

  always_comb begin
    wr_entry = 1'b0;
    wr_cnt   = 1'b0;
    cnt_next = btb_cnt[res_idx];
    if (res_valid) begin
      if (upd_taken) begin
        wr_entry = 1'b1;
        wr_cnt   = 1'b1;
        if (!res_is_cond)
          cnt_next = 2'd3;
        else if (res_hit)
          cnt_next = (btb_cnt[res_idx] == 2'd3) ? 2'd3 : btb_cnt[res_idx] + 2'd1;
        else
          cnt_next = 2'd2;
      end else if (res_hit) begin
        wr_cnt   = 1'b1;
        cnt_next = (btb_cnt[res_idx] == 2'd0) ? 2'd0 : btb_cnt[res_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++)
        btb_cnt[i] <= 2'd0;
    end else begin
      if (wr_entry)
        btb_valid[res_idx] <= 1'b1;
      if (wr_cnt)
        btb_cnt[res_idx] <= cnt_next;
    end
  end

  // Tags and targets carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (!reset && wr_entry) begin
      btb_tag[res_idx] <= res_tag;
      btb_tgt[res_idx] <= res_target;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      pc <= RESET_PC;
    else if (trap_valid)
      pc <= trap_pc;
    else if (mispredict)
      pc <= act_npc;
    else if (fetch_ready)
      pc <= pred_npc;
  end

endmodule

// File: tb/tb_ysyx_22050550_pc_predict.sv
// Directed, table-driven bench for the fetch-PC predictor with hand-computed expectations.
module tb_ysyx_22050550_pc_predict;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clock;
  logic        reset;
  logic        fetch_ready;
  logic [63:0] pc;
  logic [63:0] pred_npc;
  logic        pred_taken;
  logic        res_valid;
  logic [63:0] res_pc;
  logic        res_is_cond;
  logic        res_taken;
  logic [63:0] res_target;
  logic [63:0] res_pred_npc;
  logic        trap_valid;
  logic [63:0] trap_pc;
  logic        flush;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        fr;
    logic        rv;
    logic [63:0] rpc;
    logic        rc;
    logic        rt;
    logic [63:0] rtgt;
    logic [63:0] rpn;
    logic        tv;
    logic [63:0] tpc;
    logic [63:0] e_pc;
    logic [63:0] e_npc;
    logic        e_pt;
    logic        e_fl;
  } vec_t;

  vec_t vecs[$];

  ysyx_22050550_pc_predict #(
    .XLEN(64), .RESET_PC(64'h8000_0000), .BTB_ENTRIES(16)
  ) dut (
    .clock(clock), .reset(reset), .fetch_ready(fetch_ready),
    .pc(pc), .pred_npc(pred_npc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_cond(res_is_cond),
    .res_taken(res_taken), .res_target(res_target), .res_pred_npc(res_pred_npc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .flush(flush)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(logic fr, logic rv, logic [63:0] rpc, logic rc, logic rt,
                              logic [63:0] rtgt, logic [63:0] rpn, logic tv, logic [63:0] tpc,
                              logic [63:0] e_pc, logic [63:0] e_npc, logic e_pt, logic e_fl);
    vec_t v;
    v.fr = fr; v.rv = rv; v.rpc = rpc; v.rc = rc; v.rt = rt;
    v.rtgt = rtgt; v.rpn = rpn; v.tv = tv; v.tpc = tpc;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_pt = e_pt; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset        = 1'b0;
    fetch_ready  = v.fr;
    res_valid    = v.rv;
    res_pc       = v.rpc;
    res_is_cond  = v.rc;
    res_taken    = v.rt;
    res_target   = v.rtgt;
    res_pred_npc = v.rpn;
    trap_valid   = v.tv;
    trap_pc      = v.tpc;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check64({tag, " pc"}, pc, v.e_pc);
    check64({tag, " pred_npc"}, pred_npc, v.e_npc);
    check64({tag, " pred_taken"}, {63'd0, pred_taken}, {63'd0, v.e_pt});
    check64({tag, " flush"}, {63'd0, flush}, {63'd0, v.e_fl});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic runVec(input string tag, input vec_t v);
    @(negedge clock);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
  endtask

  initial begin
    vec_t v;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clock);

    //          fr rv rpc      rc rt rtgt      rpn       tv tpc        e_pc      e_npc     pt fl
    vecs.push_back(mk(1, 0, 0,       0, 0, 0,       0,       0, 0,       B,       B+4,      0, 0));
    vecs.push_back(mk(1, 0, 0,       0, 0, 0,       0,       0, 0,       B+4,     B+8,      0, 0));
    vecs.push_back(mk(1, 0, 0,       0, 0, 0,       0,       0, 0,       B+8,     B+'hC,    0, 0));
    vecs.push_back(mk(0, 1, B+'h10,  1, 1, B+'h100, B+'h14,  0, 0,       B+'hC,   B+'h10,   0, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       1, B+'h10,  B+'h100, B+'h104,  0, 1));
    vecs.push_back(mk(1, 0, 0,       0, 0, 0,       0,       0, 0,       B+'h10,  B+'h100,  1, 0));
    vecs.push_back(mk(0, 1, B+'h10,  1, 0, B+'h100, B+'h100, 0, 0,       B+'h100, B+'h104,  0, 1));
    vecs.push_back(mk(0, 1, B+'h10,  1, 0, B+'h100, B+'h14,  0, 0,       B+'h14,  B+'h18,   0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       1, B+'h10,  B+'h14,  B+'h18,   0, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       0, 0,       B+'h10,  B+'h14,   0, 0));
    vecs.push_back(mk(1, 1, B+'h10,  1, 1, B+'h100, B+'h14,  1, B+'h800, B+'h10,  B+'h14,   0, 1));
    vecs.push_back(mk(0, 1, B+'h10,  1, 1, B+'h100, B+'h14,  1, B+'h10,  B+'h800, B+'h804,  0, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       0, 0,       B+'h10,  B+'h100,  1, 0));
    vecs.push_back(mk(0, 1, B+'h50,  0, 1, B+'h200, B+'h54,  0, 0,       B+'h10,  B+'h100,  1, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       1, B+'h10,  B+'h200, B+'h204,  0, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       0, 0,       B+'h10,  B+'h14,   0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       1, B+'h50,  B+'h10,  B+'h14,   0, 1));
    vecs.push_back(mk(1, 0, 0,       0, 0, 0,       0,       0, 0,       B+'h50,  B+'h200,  1, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0,       1, B+'h50,  B+'h200, B+'h204,  0, 1));

    foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 4; i++)
      runVec($sformatf("hold%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B+'h50, B+'h200, 1, 0));
    runVec("hold_mispredict", mk(0, 1, B+'h50, 0, 1, B+'h300, B+'h200, 0, 0, B+'h50, B+'h200, 1, 1));
    runVec("hold_redirected", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B+'h300, B+'h304, 0, 0));

    // Reset cycle also presents a taken branch at RESET_PC that must not train the BTB.
    @(negedge clock);
    applyStimulus(mk(1, 1, B, 1, 1, B+'h900, B+4, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    runVec("post_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B, B+4, 0, 0));
    runVec("post_reset_trap", mk(0, 0, 0, 0, 0, 0, 0, 1, B+'h50, B, B+4, 0, 1));
    runVec("post_reset_miss", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, B+'h50, B+'h54, 0, 0));

    runVec("wrap_trap", mk(0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, B+'h50, B+'h54, 0, 1));
    runVec("wrap_top", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0));
    runVec("wrap_zero", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd4, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
